// File: rtl/i2c_dac_target_if.sv
// i2c_dac_target_if -- bus bundle for the I2C DAC write target.
//   scl_i, sda_i : raw (asynchronous) I2C clock and data lines seen by the target
//   sda_oe_o     : 1 = target pulls SDA low (open-drain), 0 = released
//   value_o      : last accepted 12-bit DAC code
//   sel_o        : last accepted 3-bit channel/EEPROM select
//   valid_o      : one-cycle pulse when value_o/sel_o update
//   err_o        : one-cycle pulse when a matched frame is aborted
//   busy_o       : high from a matched address until STOP or abort
// slave  : the target's view (drives the status outputs)
// master : the bus/controller side (drives SCL/SDA)
interface i2c_dac_target_if;
  logic        scl_i;
  logic        sda_i;
  logic        sda_oe_o;
  logic [11:0] value_o;
  logic [2:0]  sel_o;
  logic        valid_o;
  logic        err_o;
  logic        busy_o;

  modport slave (
    input  scl_i, sda_i,
    output sda_oe_o, value_o, sel_o, valid_o, err_o, busy_o
  );

  modport master (
    output scl_i, sda_i,
    input  sda_oe_o, value_o, sel_o, valid_o, err_o, busy_o
  );
endinterface

// File: rtl/i2c_dac_target.sv
// i2c_dac_target -- write-only I2C target that receives a 4-byte frame
// (address, command, data-high, data-low) and presents a 12-bit DAC code
// plus a 3-bit select.
//   clk_i : system clock (must run at least OSR_MIN cycles per SCL half-period)
//   rst_i : asynchronous active-high reset
//   bus   : i2c_dac_target_if.slave (SCL/SDA in, SDA pull-down, status outputs)
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN -- when defined, each
// synchronised line passes through a 3-sample majority filter (2 extra
// cycles of latency, rejects pulses of one clk_i cycle).
module i2c_dac_target #(
  parameter logic [6:0] ADDR    = 7'h60,
  parameter int         OSR_MIN = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  i2c_dac_target_if.slave bus
);

  // The majority filter needs a level to persist for at least two samples
  // plus one edge-detect cycle inside each SCL half-period.
  if (OSR_MIN < 3) begin : g_osr_check
    $error("i2c_dac_target: OSR_MIN must be at least 3");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK, ST_CMD, ST_DHI, ST_DLO, ST_WAIT_STOP
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic   scl_p0, scl_p1, sda_p0, sda_p1;
  logic   scl_f, sda_f, scl_q, sda_q;
  logic   scl_rise, scl_fall, start_det, stop_det;
  state_t state_q, state_n;
  logic   sda_oe_q, sda_oe_n, busy_q, busy_n;
  logic   valid_q, valid_n, err_q, err_n, commit;
  logic [11:0] value_q, pend_val;
  logic [2:0]  sel_q, pend_sel, bit_cnt_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  sh_q;
  logic        byte_full_q, rx_state, byte_end;

  // Stage p0/p1: two-flop synchronisers, idle-high after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= bus.scl_i;
      scl_p1 <= scl_p0;
      sda_p0 <= bus.sda_i;
      sda_p1 <= sda_p0;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;

  // Stage p2: majority of the current and two previous samples, registered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_p1};
      sda_h <= {sda_h[0], sda_p1};
      scl_f <= maj3(scl_p1, scl_h[0], scl_h[1]);
      sda_f <= maj3(sda_p1, sda_h[0], sda_h[1]);
    end
  end
`else
  assign scl_f = scl_p1;
  assign sda_f = sda_p1;
`endif

  // Previous-sample registers for edge and START/STOP detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_state  = (state_q == ST_ADDR) || (state_q == ST_CMD) ||
                     (state_q == ST_DHI)  || (state_q == ST_DLO);
  // The falling edge after the eighth data bit of a received byte
  assign byte_end  = scl_fall & byte_full_q;

  always_comb begin
    state_n  = state_q;
    sda_oe_n = sda_oe_q;
    busy_n   = busy_q;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    commit   = 1'b0;
    if (start_det || stop_det) begin
      // An abort is a START/STOP on a matched frame before it completed;
      // a completed frame parks in WAIT_STOP and ends cleanly.
      state_n  = start_det ? ST_ADDR : ST_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      err_n    = busy_q && (state_q != ST_WAIT_STOP);
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (byte_end) begin
            if (sh_q == {ADDR, 1'b0}) begin
              state_n  = ST_ACK;
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end
        end
        ST_CMD, ST_DHI, ST_DLO: begin
          if (byte_end) begin
            state_n  = ST_ACK;
            sda_oe_n = 1'b1;
          end
        end
        ST_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            unique case (byte_idx_q)
              2'd0: state_n = ST_CMD;
              2'd1: state_n = ST_DHI;
              2'd2: state_n = ST_DLO;
              default: begin
                state_n = ST_WAIT_STOP;
                commit  = 1'b1;
                valid_n = 1'b1;
              end
            endcase
          end
        end
        default: sda_oe_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      value_q     <= 12'd0;
      sel_q       <= 3'd0;
      bit_cnt_q   <= 3'd0;
      byte_full_q <= 1'b0;
      byte_idx_q  <= 2'd0;
    end else begin
      state_q  <= state_n;
      sda_oe_q <= sda_oe_n;
      busy_q   <= busy_n;
      valid_q  <= valid_n;
      err_q    <= err_n;
      if (commit) begin
        value_q <= pend_val;
        sel_q   <= pend_sel;
      end
      if (start_det || stop_det) begin
        bit_cnt_q   <= 3'd0;
        byte_full_q <= 1'b0;
        byte_idx_q  <= 2'd0;
      end else begin
        if (rx_state && scl_rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_full_q <= 1'b1;
        end
        if (scl_fall) byte_full_q <= 1'b0;
        if ((state_q == ST_ACK) && scl_fall) byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

  // Shift register and pending fields carry data only; no reset needed
  always_ff @(posedge clk_i) begin
    if (rx_state && scl_rise) sh_q <= {sh_q[6:0], sda_f};
    if (byte_end) begin
      unique case (state_q)
        ST_CMD:  pend_sel       <= sh_q[7:5];
        ST_DHI:  pend_val[11:4] <= sh_q;
        ST_DLO:  pend_val[3:0]  <= sh_q[7:4];
        default: ;
      endcase
    end
  end

  assign bus.sda_oe_o = sda_oe_q;
  assign bus.value_o  = value_q;
  assign bus.sel_o    = sel_q;
  assign bus.valid_o  = valid_q;
  assign bus.err_o    = err_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_i2c_dac_target.sv
// tb_i2c_dac_target -- randomized and directed I2C write frames against a
// frame-level reference model (address match, byte count, field extraction).
module tb_i2c_dac_target;
  localparam logic [6:0] ADDR = 7'h60;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_dac_target_if bus ();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe_o;

  i2c_dac_target #(.ADDR(ADDR), .OSR_MIN(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [11:0] m_value = 12'd0;
  logic [2:0]  m_sel = 3'd0;

  always @(negedge clk) begin
    if (bus.valid_o) valid_cnt++;
    if (bus.err_o) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(HALF);
    sda_m = 1'b0; tick(HALF);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(HALF);
    scl_m = 1'b1; tick(HALF);
    sda_m = 1'b0; tick(HALF);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(HALF);
    scl_m = 1'b1; tick(HALF);
    sda_m = 1'b1; tick(HALF);
  endtask

  // Sends one byte and clocks the ACK slot; optionally asserts reset while
  // the target is holding the ACK and checks the pull-down drops at once.
  task automatic send_byte(input logic [7:0] b, input bit rst_mid, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(HALF);
      scl_m = 1'b1; tick(HALF);
      scl_m = 1'b0; tick(2);
    end
    sda_m = 1'b1; tick(HALF);
    scl_m = 1'b1; tick(HALF / 2);
    ack = !bus.sda_i;
    if (rst_mid) begin
      rst = 1'b1;
      #1;
      chk("rst_mid_oe", 32'(bus.sda_oe_o), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_mid_value", 32'(bus.value_o), 32'd0);
    end
    tick(HALF / 2);
    scl_m = 1'b0; tick(2);
  endtask

  // One frame against the model: only a write to ADDR is acknowledged, and
  // only its first four bytes; four bytes make a complete frame.
  task automatic do_frame(input int n, input logic [7:0] b[8], input bit with_start,
                          input bit end_rep);
    int v0, e0;
    bit matched, complete, ack;
    v0 = valid_cnt;
    e0 = err_cnt;
    matched  = (b[0] == {ADDR, 1'b0});
    complete = matched && (n >= 4);
    if (with_start) i2c_start();
    for (int i = 0; i < n; i++) begin
      send_byte(b[i], 1'b0, ack);
      chk($sformatf("ack%0d", i), 32'(ack), 32'(matched && (i < 4)));
      if (i == 0) chk("busy_addr", 32'(bus.busy_o), 32'(matched));
    end
    if (end_rep) i2c_rstart(); else i2c_stop();
    tick(4);
    if (complete) begin
      m_value = {b[2], b[3][7:4]};
      m_sel   = b[1][7:5];
    end
    chk("valid_pulses", 32'(valid_cnt - v0), 32'(complete));
    chk("err_pulses", 32'(err_cnt - e0), 32'(matched && !complete));
    chk("value", 32'(bus.value_o), 32'(m_value));
    chk("sel", 32'(bus.sel_o), 32'(m_sel));
    chk("busy_end", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    logic [7:0] fb[8];
    bit ack, seen_busy, pend_rep;
    int v0, e0, n;

    tick(5);
    chk("rst_oe", 32'(bus.sda_oe_o), 32'd0);
    chk("rst_value", 32'(bus.value_o), 32'd0);
    chk("rst_sel", 32'(bus.sel_o), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;
    tick(5);

    fb = '{8'hC0, 8'h60, 8'h83, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    do_frame(4, fb, 1'b1, 1'b0);
    chk("dir1_value", 32'(bus.value_o), 32'h834);
    fb = '{8'hC2, 8'h60, 8'hFA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_frame(4, fb, 1'b1, 1'b0);
    fb = '{8'hC0, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_frame(2, fb, 1'b1, 1'b0);
    fb = '{8'hC0, 8'h40, 8'hFA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_frame(3, fb, 1'b1, 1'b1);
    fb = '{8'hC0, 8'h60, 8'h9C, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    do_frame(4, fb, 1'b0, 1'b0);
    chk("dir4_value", 32'(bus.value_o), 32'h9C4);

    // Reset during the data-high ACK, then the rest of that frame is ignored
    i2c_start();
    send_byte(8'hC0, 1'b0, ack); chk("r_ack0", 32'(ack), 32'd1);
    send_byte(8'h20, 1'b0, ack); chk("r_ack1", 32'(ack), 32'd1);
    send_byte(8'h64, 1'b1, ack); chk("r_ack2", 32'(ack), 32'd1);
    m_value = 12'd0;
    m_sel   = 3'd0;
    tick(3);
    rst = 1'b0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'h00, 1'b0, ack); chk("r_ack3", 32'(ack), 32'd0);
    i2c_stop();
    tick(4);
    chk("r_valid", 32'(valid_cnt - v0), 32'd0);
    chk("r_err", 32'(err_cnt - e0), 32'd0);
    fb = '{8'hC0, 8'h20, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_frame(4, fb, 1'b1, 1'b0);
    chk("dir5_value", 32'(bus.value_o), 32'h640);
    chk("dir5_sel", 32'(bus.sel_o), 32'd1);

    // One-cycle SDA low glitch with SCL high on an idle bus
    tick(10);
    e0 = err_cnt;
    seen_busy = 1'b0;
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.busy_o) seen_busy = 1'b1;
    end
    chk("glitch_busy", 32'(seen_busy), 32'd0);
    chk("glitch_err", 32'(err_cnt - e0), 32'd0);
    fb = '{8'hC0, 8'hE0, 8'h5A, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
    do_frame(4, fb, 1'b1, 1'b0);

    pend_rep = 1'b0;
    for (int k = 0; k < 25; k++) begin
      n = int'($urandom_range(1, 6));
      fb[0] = ($urandom_range(0, 1) == 1) ? 8'hC0 : 8'($urandom);
      for (int i = 1; i < 8; i++) fb[i] = 8'($urandom);
      do_frame(n, fb, !pend_rep, $urandom_range(0, 3) == 0);
      pend_rep = (scl_m == 1'b0) && (sda_m == 1'b0);
    end
    if (pend_rep) i2c_stop();
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
